// File: rtl/hack_boot_sequencer.sv
// Hack CPU boot/reload sequencer.
// Holds the CPU in reset, receives a program as a byte stream (high byte
// first), writes each 16-bit word into instruction ROM starting at address 0,
// then keeps cpu_rst high for RST_CYCLES more cycles before letting it go.
module hack_boot_sequencer #(
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned DEPTH      = 32768,
  parameter int unsigned RST_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              rom_we,
  output logic [ADDR_W-1:0] rom_addr,
  output logic [15:0]       rom_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [2:0] S_HOLD    = 3'd0;
  localparam logic [2:0] S_RX_HI   = 3'd1;
  localparam logic [2:0] S_RX_LO   = 3'd2;
  localparam logic [2:0] S_WRITE   = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;
  localparam logic [2:0] S_RUN     = 3'd5;

  localparam int unsigned        RC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RC_W-1:0]    RC_LAST = RC_W'(RST_CYCLES - 1);
  localparam logic [ADDR_W:0]    DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]    CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [2:0]        state, state_n;
  logic [ADDR_W:0]   len_q, len_n;
  logic [ADDR_W:0]   cnt, cnt_n;
  logic [RC_W-1:0]   rel_cnt, rel_n;
  logic [7:0]        hi_q, hi_n;
  logic [ADDR_W-1:0] addr_n;
  logic [15:0]       wdata_n;
  logic              err_n;
  logic              hs;

  assign hs = rx_valid && rx_ready;

  // Next-state and datapath decisions; outputs are registered from state_n.
  always_comb begin
    state_n = state;
    len_n   = len_q;
    cnt_n   = cnt;
    rel_n   = rel_cnt;
    hi_n    = hi_q;
    addr_n  = rom_addr;
    wdata_n = rom_wdata;
    err_n   = err;
    case (state)
      S_HOLD, S_RUN: begin
        if (start) begin
          if (len > DEPTH_L) begin
            err_n   = 1'b1;
            state_n = S_HOLD;
          end else begin
            err_n = 1'b0;
            if (len == '0) begin
              rel_n   = '0;
              state_n = S_RELEASE;
            end else begin
              len_n   = len;
              cnt_n   = '0;
              state_n = S_RX_HI;
            end
          end
        end
      end
      S_RX_HI: begin
        if (hs) begin
          hi_n    = rx_data;
          state_n = S_RX_LO;
        end
      end
      S_RX_LO: begin
        if (hs) begin
          addr_n  = cnt[ADDR_W-1:0];
          wdata_n = {hi_q, rx_data};
          state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        // Counter is ADDR_W+1 bits so len=DEPTH compares before any wrap.
        if (cnt == len_q - CNT_ONE) begin
          rel_n   = '0;
          state_n = S_RELEASE;
        end else begin
          cnt_n   = cnt + CNT_ONE;
          state_n = S_RX_HI;
        end
      end
      S_RELEASE: begin
        if (rel_cnt == RC_LAST) begin
          state_n = S_RUN;
        end else begin
          rel_n = rel_cnt + 1'b1;
        end
      end
      default: state_n = S_HOLD;
    endcase
  end

  // State, datapath and registered output decodes; reset overrides everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_HOLD;
      len_q     <= '0;
      cnt       <= '0;
      rel_cnt   <= '0;
      hi_q      <= '0;
      rom_addr  <= '0;
      rom_wdata <= '0;
      err       <= 1'b0;
      cpu_rst   <= 1'b1;
      rx_ready  <= 1'b0;
      rom_we    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      len_q     <= len_n;
      cnt       <= cnt_n;
      rel_cnt   <= rel_n;
      hi_q      <= hi_n;
      rom_addr  <= addr_n;
      rom_wdata <= wdata_n;
      err       <= err_n;
      cpu_rst   <= (state_n != S_RUN);
      rx_ready  <= (state_n == S_RX_HI) || (state_n == S_RX_LO);
      rom_we    <= (state_n == S_WRITE);
      busy      <= (state_n == S_RX_HI) || (state_n == S_RX_LO) ||
                   (state_n == S_WRITE) || (state_n == S_RELEASE);
      done      <= (state_n == S_RUN);
    end
  end

endmodule

// File: tb/tb_hack_boot_sequencer.sv
// Testbench for hack_boot_sequencer: a cycle table for the basic load, then
// directed sequences for stalls, illegal/zero lengths, reset abort and reload.
module tb_hack_boot_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, rx_valid;
  logic [15:0] len;
  logic [7:0]  rx_data;
  logic        rx_ready, rom_we, cpu_rst, busy, done, err;
  logic [14:0] rom_addr;
  logic [15:0] rom_wdata;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [30:0] wq[$];

  hack_boot_sequencer #(.ADDR_W(15), .DEPTH(32768), .RST_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rom_we(rom_we), .rom_addr(rom_addr), .rom_wdata(rom_wdata),
    .cpu_rst(cpu_rst), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // Record every ROM write, sampled mid-cycle.
  always @(negedge clk) if (rom_we === 1'b1) wq.push_back({rom_addr, rom_wdata});

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  typedef struct {
    logic        start;
    logic [15:0] len;
    logic        vld;
    logic [7:0]  data;
    logic        cpu_rst, rdy, we;
    logic [14:0] addr;
    logic [15:0] wdata;
    logic        busy, done, err;
  } vec_t;

  function automatic vec_t mk(input logic s, input logic [15:0] l, input logic v,
                              input logic [7:0] d, input logic cr, input logic rd,
                              input logic w, input logic [14:0] a, input logic [15:0] wd,
                              input logic b, input logic dn, input logic e);
    vec_t r;
    r.start = s; r.len = l; r.vld = v; r.data = d;
    r.cpu_rst = cr; r.rdy = rd; r.we = w; r.addr = a; r.wdata = wd;
    r.busy = b; r.done = dn; r.err = e;
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic put_byte(input logic [7:0] b);
    logic hs;
    logic ok;
    ok = 1'b0;
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      hs = rx_ready;
      tick;
      if (hs) begin
        ok = 1'b1;
        break;
      end
    end
    check("byte_handshake", ok, 1);
  endtask

  task automatic wait_run(input int max);
    int n;
    n = 0;
    while (cpu_rst === 1'b1 && n < max) begin
      tick;
      n++;
    end
    check("run_reached", cpu_rst, 0);
  endtask

  task automatic check_wr(input string name, input int idx, input logic [14:0] a,
                          input logic [15:0] d);
    logic [30:0] v;
    v = (idx < wq.size()) ? wq[idx] : '1;
    check(name, v, {a, d});
  endtask

  vec_t vt[15];
  int   s;

  initial begin
    // Idle after reset, then a len=2 load of 00 0F E3 08.
    for (int i = 0; i < 5; i++) vt[i] = mk(0, 0, 0, 8'h00, 1, 0, 0, 0, 16'h0000, 0, 0, 0);
    vt[5]  = mk(1, 2, 0, 8'h00, 1, 1, 0, 0, 16'h0000, 1, 0, 0);
    vt[6]  = mk(0, 0, 1, 8'h00, 1, 1, 0, 0, 16'h0000, 1, 0, 0);
    vt[7]  = mk(0, 0, 1, 8'h0F, 1, 0, 1, 0, 16'h000F, 1, 0, 0);
    vt[8]  = mk(0, 0, 1, 8'hE3, 1, 1, 0, 0, 16'h000F, 1, 0, 0);
    vt[9]  = mk(0, 0, 1, 8'hE3, 1, 1, 0, 0, 16'h000F, 1, 0, 0);
    vt[10] = mk(0, 0, 1, 8'h08, 1, 0, 1, 1, 16'hE308, 1, 0, 0);
    vt[11] = mk(0, 0, 1, 8'h55, 1, 0, 0, 1, 16'hE308, 1, 0, 0);
    vt[12] = mk(0, 0, 0, 8'h00, 1, 0, 0, 1, 16'hE308, 1, 0, 0);
    vt[13] = mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 16'hE308, 0, 1, 0);
    vt[14] = mk(0, 0, 0, 8'h00, 0, 0, 0, 1, 16'hE308, 0, 1, 0);

    rst = 1'b1; start = 1'b0; len = '0; rx_valid = 1'b0; rx_data = '0;
    tick;
    tick;
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_rdy", rx_ready, 0);
    check("rst_we", rom_we, 0);
    check("rst_addr", rom_addr, 0);
    check("rst_wdata", rom_wdata, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      start = vt[i].start; len = vt[i].len; rx_valid = vt[i].vld; rx_data = vt[i].data;
      tick;
      check($sformatf("v%0d_cpu_rst", i), cpu_rst, vt[i].cpu_rst);
      check($sformatf("v%0d_rdy", i), rx_ready, vt[i].rdy);
      check($sformatf("v%0d_we", i), rom_we, vt[i].we);
      check($sformatf("v%0d_addr", i), rom_addr, vt[i].addr);
      check($sformatf("v%0d_wdata", i), rom_wdata, vt[i].wdata);
      check($sformatf("v%0d_busy", i), busy, vt[i].busy);
      check($sformatf("v%0d_done", i), done, vt[i].done);
      check($sformatf("v%0d_err", i), err, vt[i].err);
    end
    start = 1'b0; rx_valid = 1'b0;

    // Reload from RUN, len=3, with a 4-cycle stall inside word 1.
    wq.delete();
    start = 1'b1; len = 16'd3;
    tick;
    start = 1'b0;
    check("t3_cpu_rst", cpu_rst, 1);
    check("t3_done", done, 0);
    check("t3_rdy", rx_ready, 1);
    put_byte(8'h12); put_byte(8'h34); put_byte(8'hAB);
    rx_valid = 1'b0; rx_data = 8'hFF;
    repeat (4) tick;
    check("t3_stall_rdy", rx_ready, 1);
    check("t3_stall_busy", busy, 1);
    check("t3_stall_writes", wq.size(), 1);
    put_byte(8'hCD); put_byte(8'h01); put_byte(8'h02);
    rx_valid = 1'b0;
    wait_run(40);
    check("t3_writes", wq.size(), 3);
    check_wr("t3_w0", 0, 15'd0, 16'h1234);
    check_wr("t3_w1", 1, 15'd1, 16'hABCD);
    check_wr("t3_w2", 2, 15'd2, 16'h0102);
    check("t3_done_end", done, 1);

    // Illegal len from RUN drops to HOLD with err set.
    start = 1'b1; len = 16'd40000;
    tick;
    start = 1'b0;
    check("run_bad_err", err, 1);
    check("run_bad_cpu_rst", cpu_rst, 1);
    check("run_bad_done", done, 0);
    check("run_bad_busy", busy, 0);
    tick;
    check("run_bad_rdy", rx_ready, 0);

    // From HOLD: len=32769 rejected, then len=0 releases with no writes.
    wq.delete();
    start = 1'b1; len = 16'd32769;
    tick;
    start = 1'b0;
    check("t4_err", err, 1);
    check("t4_busy", busy, 0);
    check("t4_cpu_rst", cpu_rst, 1);
    repeat (3) tick;
    check("t4_rdy", rx_ready, 0);
    check("t4_no_writes", wq.size(), 0);
    start = 1'b1; len = 16'd0;
    tick;
    start = 1'b0;
    s = cyc;
    check("t4z_err", err, 0);
    check("t4z_busy", busy, 1);
    check("t4z_cpu_rst", cpu_rst, 1);
    wait_run(20);
    check("t4z_latency", cyc - s + 1, 3);
    check("t4z_done", done, 1);
    check("t4z_writes", wq.size(), 0);

    // len=DEPTH is legal.
    start = 1'b1; len = 16'd32768;
    tick;
    start = 1'b0;
    check("depth_err", err, 0);
    check("depth_rdy", rx_ready, 1);
    rst = 1'b1;
    tick;
    rst = 1'b0;

    // Reset during the low byte of word 2 of a len=4 load.
    start = 1'b1; len = 16'd4;
    tick;
    start = 1'b0;
    wq.delete();
    put_byte(8'h11); put_byte(8'h22); put_byte(8'h33); put_byte(8'h44); put_byte(8'h55);
    rx_data = 8'h66; rx_valid = 1'b1; rst = 1'b1;
    tick;
    rst = 1'b0;
    check("t5_cpu_rst", cpu_rst, 1);
    check("t5_rdy", rx_ready, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_we", rom_we, 0);
    repeat (5) tick;
    rx_valid = 1'b0;
    check("t5_writes", wq.size(), 2);
    check_wr("t5_w0", 0, 15'd0, 16'h1122);
    check_wr("t5_w1", 1, 15'd1, 16'h3344);
    check("t5_rdy_after", rx_ready, 0);

    // Reach RUN, then reload len=1; a start during RX_LO must be ignored.
    start = 1'b1; len = 16'd0;
    tick;
    start = 1'b0;
    wait_run(20);
    check("t6_pre_done", done, 1);
    wq.delete();
    start = 1'b1; len = 16'd1;
    tick;
    start = 1'b0;
    s = cyc;
    check("t6_cpu_rst", cpu_rst, 1);
    check("t6_done", done, 0);
    put_byte(8'hAB);
    start = 1'b1; len = 16'd2;
    put_byte(8'hCD);
    start = 1'b0; rx_valid = 1'b0;
    check("t6_we", rom_we, 1);
    check("t6_addr", rom_addr, 0);
    check("t6_wdata", rom_wdata, 16'hABCD);
    wait_run(20);
    check("t6_latency", cyc - s + 1, 6);
    check("t6_writes", wq.size(), 1);
    check("t6_done_end", done, 1);
    check("t6_busy_end", busy, 0);
    check("t6_err", err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
